seg7_scan_controller: RTL

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It consumes the 1 kHz clock-enable strobe from the team's clock divider and rotates through the digits, advancing one digit per strobe. Each digit switch is followed by an anti-ghosting blanking interval, and brightness is set by PWM on the anode. It sits between the divider and the display pins, and captures display data once per frame so that each frame shows a coherent value.

---
 rtl/seg7_scan_if.sv | 25 ++
 rtl/seg7_scan_controller.sv | 123 ++++++++++++
 2 files changed

// File: rtl/seg7_scan_if.sv
// Display-side bundle of the seven-segment scan controller: scan strobe,
// frame data in, and active-low pin drive plus frame marker out.
interface seg7_scan_if #(
  parameter int DIGITS = 8
);
  logic                  ce;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dig_en;
  logic [DIGITS-1:0]     dp_en;
  logic [2:0]            bright;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame;

  modport master (
    output ce, data, dig_en, dp_en, bright,
    input  an, seg, dp, frame
  );

  modport slave (
    input  ce, data, dig_en, dp_en, bright,
    output an, seg, dp, frame
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// Multiplexed 8-digit common-anode scanner: one digit per CE strobe, blanking
// guard after each switch, PWM brightness, frame-coherent shadow data.
module seg7_scan_controller #(
  parameter int DIGITS = 8,
  parameter int GUARD  = 16
) (
  input  logic         clk,
  input  logic         rst,
  seg7_scan_if.slave   bus
);

  localparam int IW = 3;

  typedef enum logic {S_GUARD, S_ON} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            gcnt_q, gcnt_d;
  logic [2:0]            pcnt_q, pcnt_d;
  logic [4*DIGITS-1:0]   sh_data_q, sh_data_d;
  logic [DIGITS-1:0]     sh_en_q, sh_en_d;
  logic [DIGITS-1:0]     sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_q, frame_d;
  logic [3:0]            nib;
  logic                  lit;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gcnt_d    = gcnt_q;
    pcnt_d    = pcnt_q;
    sh_data_d = sh_data_q;
    sh_en_d   = sh_en_q;
    sh_dp_d   = sh_dp_q;
    frame_d   = 1'b0;

    if (bus.ce) begin
      idx_d   = (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + 1'b1;
      state_d = S_GUARD;
      gcnt_d  = '0;
      // Snapshot inputs at the wrap so a whole frame shows one coherent value
      if (idx_d == '0) begin
        sh_data_d = bus.data;
        sh_en_d   = bus.dig_en;
        sh_dp_d   = bus.dp_en;
        frame_d   = 1'b1;
      end
    end else begin
      case (state_q)
        S_GUARD: begin
          gcnt_d = gcnt_q + 8'd1;
          if (gcnt_q == 8'(GUARD-1)) begin
            state_d = S_ON;
            pcnt_d  = '0;
          end
        end
        default: pcnt_d = pcnt_q + 3'd1;
      endcase
    end

    // Outputs follow the next-state values so the first ON edge is already lit
    nib  = sh_data_d[{idx_d, 2'b00} +: 4];
    lit  = (state_d == S_ON) && sh_en_d[idx_d] && (pcnt_d <= bus.bright);
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_d);
      seg_d = hex7(nib);
      dp_d  = ~sh_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_GUARD;
      idx_q     <= '0;
      gcnt_q    <= '0;
      pcnt_q    <= '0;
      sh_data_q <= '0;
      sh_en_q   <= '0;
      sh_dp_q   <= '0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gcnt_q    <= gcnt_d;
      pcnt_q    <= pcnt_d;
      sh_data_q <= sh_data_d;
      sh_en_q   <= sh_en_d;
      sh_dp_q   <= sh_dp_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.frame = frame_q;

endmodule
